// File: rtl/voice_pkg.sv
// Shared definitions for the voice frame scheduler.
//   FRAME_LEN : samples per FFT frame (and ring-buffer depth)
//   SMP_W     : sample width (signed)
//   PTR_W     : ring-buffer pointer width
//   CNT_W     : counter width able to hold FRAME_LEN itself
//   state_t   : scheduler state encoding
//   sat_inc() : counter increment that saturates at FRAME_LEN
package voice_pkg;

  localparam int FRAME_LEN = 256;
  localparam int SMP_W     = 16;
  localparam int PTR_W     = 8;
  localparam int CNT_W     = PTR_W + 1;

  localparam logic [CNT_W-1:0] FRAME_CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [PTR_W-1:0] LAST_BEAT      = PTR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  // Hop counting never needs to exceed a full frame, so clamp there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= FRAME_CNT_FULL) ? FRAME_CNT_FULL : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/voice_frame_sched_if.sv
// Stream bundle between the scheduler and its neighbours.
//   Sample side : i_smp_valid / i_smp_data in, o_smp_ready out
//   FFT side    : o_fft_valid / o_fft_data / o_fft_last out, i_fft_ready in
// Modports:
//   slave  - the scheduler (consumes samples, produces FFT beats)
//   master - the environment (produces samples, consumes FFT beats)
interface voice_frame_sched_if;
  import voice_pkg::*;

  logic                    i_smp_valid;
  logic signed [SMP_W-1:0] i_smp_data;
  logic                    o_smp_ready;
  logic                    o_fft_valid;
  logic signed [SMP_W-1:0] o_fft_data;
  logic                    o_fft_last;
  logic                    i_fft_ready;

  modport slave (
    input  i_smp_valid, i_smp_data, i_fft_ready,
    output o_smp_ready, o_fft_valid, o_fft_data, o_fft_last
  );

  modport master (
    output i_smp_valid, i_smp_data, i_fft_ready,
    input  o_smp_ready, o_fft_valid, o_fft_data, o_fft_last
  );

endinterface

// File: rtl/voice_ring_buf.sv
// Sample ring buffer: one synchronous write port, one asynchronous read port.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : combinational read data
// Contents are not reset; the scheduler never reads a location before
// it has been written since the last start.
module voice_ring_buf #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic        [ADDR_W-1:0] i_waddr,
  input  logic signed [DATA_W-1:0] i_wdata,
  input  logic        [ADDR_W-1:0] i_raddr,
  output logic signed [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic signed [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/voice_frame_sched.sv
// Voice frame scheduler: collects signed samples into a 256-entry ring and
// streams overlapping 256-sample frames to an FFT every hop samples.
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   i_start     : begin collection (honoured in IDLE only)
//   i_stop      : return to IDLE (after current frame when streaming)
//   i_hop       : hop size minus one, latched on accepted start
//   bus         : sample input stream and FFT output stream (slave side)
//   o_busy      : high whenever not IDLE
//   o_overrun   : sticky, sample offered but refused outside IDLE
//   o_frame_cnt : frames completed since start (wrapping)
module voice_frame_sched
  import voice_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [PTR_W-1:0]   i_hop,
  voice_frame_sched_if.slave bus,
  output logic               o_busy,
  output logic               o_overrun,
  output logic [15:0]        o_frame_cnt
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_wp;
  logic [PTR_W-1:0]   r_base;
  logic [PTR_W-1:0]   r_rd_idx;
  logic [CNT_W-1:0]   r_fill_cnt;
  logic [CNT_W-1:0]   r_hop_cnt;
  logic [PTR_W-1:0]   r_hop;
  logic               r_stop_pend;
  logic [15:0]        r_frame_cnt;
  logic               r_overrun;

  logic               w_smp_ready;
  logic               w_smp_acc;
  logic               w_beat_acc;
  logic               w_start_acc;
  logic               w_enter_stream;
  logic               w_frame_done;
  logic [PTR_W-1:0]   w_wp_nxt;
  logic [PTR_W-1:0]   w_raddr;
  logic [CNT_W-1:0]   w_fill_inc;
  logic [CNT_W-1:0]   w_hop_inc;
  logic [CNT_W-1:0]   w_hop_len;
  logic signed [SMP_W-1:0] w_rdata;

  voice_ring_buf #(
    .DATA_W (SMP_W),
    .ADDR_W (PTR_W)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_smp_acc),
    .i_waddr (r_wp),
    .i_wdata (bus.i_smp_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // While streaming, a write may only land on a slot whose frame sample
  // has already been handed to the FFT: writes trail reads.
  always_comb begin
    w_smp_ready = 1'b0;
    case (r_state)
      ST_FILL,
      ST_WAIT:   w_smp_ready = 1'b1;
      ST_STREAM: w_smp_ready = (r_hop_cnt < {1'b0, r_rd_idx});
      default:   w_smp_ready = 1'b0;
    endcase
  end

  assign w_smp_acc  = bus.i_smp_valid & w_smp_ready;
  assign w_beat_acc = (r_state == ST_STREAM) & bus.i_fft_ready;
  assign w_wp_nxt   = r_wp + PTR_W'(w_smp_acc);
  assign w_raddr    = r_base + r_rd_idx;
  assign w_fill_inc = r_fill_cnt + CNT_W'(w_smp_acc);
  assign w_hop_inc  = w_smp_acc ? sat_inc(r_hop_cnt) : r_hop_cnt;
  assign w_hop_len  = {1'b0, r_hop} + CNT_W'(1);

  // Fill and hop thresholds look at the count including this cycle's
  // sample, so the frame is launched in the same cycle its newest sample
  // is written.
  always_comb begin
    w_state_nxt    = r_state;
    w_start_acc    = 1'b0;
    w_enter_stream = 1'b0;
    w_frame_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_start_acc = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (i_stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_fill_inc == FRAME_CNT_FULL) begin
          w_enter_stream = 1'b1;
          w_state_nxt    = ST_STREAM;
        end
      end
      ST_WAIT: begin
        if (i_stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_hop_inc >= w_hop_len) begin
          w_enter_stream = 1'b1;
          w_state_nxt    = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_beat_acc && (r_rd_idx == LAST_BEAT)) begin
          w_frame_done = 1'b1;
          w_state_nxt  = (r_stop_pend || i_stop) ? ST_IDLE : ST_WAIT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_wp        <= '0;
      r_base      <= '0;
      r_rd_idx    <= '0;
      r_fill_cnt  <= '0;
      r_hop_cnt   <= '0;
      r_hop       <= '0;
      r_stop_pend <= 1'b0;
      r_frame_cnt <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc) begin
        r_wp        <= '0;
        r_fill_cnt  <= '0;
        r_hop_cnt   <= '0;
        r_hop       <= i_hop;
        r_stop_pend <= 1'b0;
        r_frame_cnt <= '0;
        r_overrun   <= 1'b0;
      end else begin
        r_wp <= w_wp_nxt;
        if (w_smp_acc && (r_state == ST_FILL)) r_fill_cnt <= w_fill_inc;

        if (w_enter_stream)
          r_hop_cnt <= '0;
        else if (w_smp_acc && ((r_state == ST_WAIT) || (r_state == ST_STREAM)))
          r_hop_cnt <= sat_inc(r_hop_cnt);

        // Oldest sample of the frame sits just past the newest write.
        if (w_enter_stream) begin
          r_base   <= w_wp_nxt;
          r_rd_idx <= '0;
        end else if (w_beat_acc) begin
          r_rd_idx <= r_rd_idx + PTR_W'(1);
        end

        if (w_frame_done)
          r_stop_pend <= 1'b0;
        else if ((r_state == ST_STREAM) && i_stop)
          r_stop_pend <= 1'b1;

        if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;

        if ((r_state != ST_IDLE) && bus.i_smp_valid && !w_smp_ready)
          r_overrun <= 1'b1;
      end
    end
  end

  assign bus.o_smp_ready = w_smp_ready;
  assign bus.o_fft_valid = (r_state == ST_STREAM);
  assign bus.o_fft_data  = (r_state == ST_STREAM) ? w_rdata : '0;
  assign bus.o_fft_last  = (r_state == ST_STREAM) && (r_rd_idx == LAST_BEAT);
  assign o_busy          = (r_state != ST_IDLE);
  assign o_overrun       = r_overrun;
  assign o_frame_cnt     = r_frame_cnt;

endmodule
